// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module : riscv_mem_pkg
// Brief  : Shared encodings and geometry for the data cache and its memory port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_ALLOC = 2'd2
  } dcache_state_e;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_W        = 2;
  localparam int MEM_ADDR_W      = 28;
  localparam int PROC_ADDR_W     = 30;

endpackage

`default_nettype wire

// File: rtl/dcache_line_array.sv
// ============================================================================
// Module : dcache_line_array
// Brief  : Valid/dirty/tag/data storage with a word-write (store hit) port and
//          a block-write (fill) port. Only valid and dirty bits are reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dcache_line_array
  import riscv_mem_pkg::*;
#(
  parameter int BIT_W = 32,
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = PROC_ADDR_W - OFFSET_W - IDX_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic                             rd_valid,
  output logic                             rd_dirty,
  output logic [TAG_W-1:0]                 rd_tag,
  output logic [WORDS_PER_BLOCK*BIT_W-1:0] rd_block,
  input  logic                             ww_en,
  input  logic [IDX_W-1:0]                 ww_idx,
  input  logic [OFFSET_W-1:0]              ww_off,
  input  logic [BIT_W-1:0]                 ww_data,
  input  logic                             bw_en,
  input  logic [IDX_W-1:0]                 bw_idx,
  input  logic [TAG_W-1:0]                 bw_tag,
  input  logic [WORDS_PER_BLOCK*BIT_W-1:0] bw_data
);

  logic [LINES-1:0]                 r_valid;
  logic [LINES-1:0]                 r_dirty;
  logic [TAG_W-1:0]                 r_tag  [LINES];
  logic [WORDS_PER_BLOCK*BIT_W-1:0] r_data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (bw_en) begin
      r_valid[bw_idx] <= 1'b1;
      r_dirty[bw_idx] <= 1'b0;
    end else if (ww_en) begin
      r_dirty[ww_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bw_en) begin
      r_tag[bw_idx]  <= bw_tag;
      r_data[bw_idx] <= bw_data;
    end else if (ww_en) begin
      r_data[ww_idx][ww_off*BIT_W +: BIT_W] <= ww_data;
    end
  end

  assign rd_valid = r_valid[rd_idx];
  assign rd_dirty = r_dirty[rd_idx];
  assign rd_tag   = r_tag[rd_idx];
  assign rd_block = r_data[rd_idx];

endmodule

`default_nettype wire

// File: rtl/riscv_dcache.sv
// ============================================================================
// Module : riscv_dcache
// Brief  : Direct-mapped write-back/write-allocate data cache with 4-word
//          blocks. Define DCACHE_STATS_EN to add hit_cnt/miss_cnt outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module riscv_dcache
  import riscv_mem_pkg::*;
#(
  parameter int BIT_W = 32,
  parameter int LINES = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             proc_read,
  input  logic                             proc_write,
  input  logic [PROC_ADDR_W-1:0]           proc_addr,
  input  logic [BIT_W-1:0]                 proc_wdata,
  output logic [BIT_W-1:0]                 proc_rdata,
  output logic                             proc_stall,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [MEM_ADDR_W-1:0]            mem_addr,
  output logic [WORDS_PER_BLOCK*BIT_W-1:0] mem_wdata,
  input  logic [WORDS_PER_BLOCK*BIT_W-1:0] mem_rdata,
  input  logic                             mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                      hit_cnt,
  output logic [31:0]                      miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = PROC_ADDR_W - OFFSET_W - IDX_W;
  localparam int BLK_W = WORDS_PER_BLOCK * BIT_W;

  dcache_state_e r_state, w_next;

  logic [OFFSET_W-1:0] w_off;
  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_req, w_hit, w_idle_hit;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [BLK_W-1:0]    rd_block;

  logic                  r_mem_read, r_mem_write;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [BLK_W-1:0]      r_mem_wdata;
  logic [IDX_W-1:0]      r_miss_idx;
  logic [TAG_W-1:0]      r_miss_tag;

  assign w_off = proc_addr[OFFSET_W-1:0];
  assign w_idx = proc_addr[OFFSET_W +: IDX_W];
  assign w_tag = proc_addr[PROC_ADDR_W-1 -: TAG_W];

  dcache_line_array #(
    .BIT_W (BIT_W),
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (w_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_block (rd_block),
    .ww_en    (proc_write && w_idle_hit),
    .ww_idx   (w_idx),
    .ww_off   (w_off),
    .ww_data  (proc_wdata),
    .bw_en    ((r_state == ST_ALLOC) && mem_ready),
    .bw_idx   (r_miss_idx),
    .bw_tag   (r_miss_tag),
    .bw_data  (mem_rdata)
  );

  assign w_req      = proc_read | proc_write;
  assign w_hit      = rd_valid && (rd_tag == w_tag);
  assign w_idle_hit = (r_state == ST_IDLE) && w_hit;
  assign proc_stall = w_req && !w_idle_hit;
  assign proc_rdata = (proc_read && !proc_stall) ? rd_block[w_off*BIT_W +: BIT_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !w_hit) w_next = (rd_valid && rd_dirty) ? ST_WB : ST_ALLOC;
      end
      ST_WB:    if (mem_ready) w_next = ST_ALLOC;
      ST_ALLOC: if (mem_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Miss index/tag are latched so the fill completes even if the request drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_miss_idx  <= '0;
      r_miss_tag  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_next == ST_WB) begin
            r_miss_idx  <= w_idx;
            r_miss_tag  <= w_tag;
            r_mem_write <= 1'b1;
            r_mem_addr  <= {rd_tag, w_idx};
            r_mem_wdata <= rd_block;
          end else if (w_next == ST_ALLOC) begin
            r_miss_idx <= w_idx;
            r_miss_tag <= w_tag;
            r_mem_read <= 1'b1;
            r_mem_addr <= {w_tag, w_idx};
          end
        end
        ST_WB: begin
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= {r_miss_tag, r_miss_idx};
          end
        end
        ST_ALLOC: if (mem_ready) r_mem_read <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_req && w_idle_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
      if ((r_state == ST_IDLE) && (w_next != ST_IDLE) && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_dcache.sv
// ============================================================================
// Module : tb_riscv_dcache
// Brief  : Directed bench for riscv_dcache with a latency-programmable memory.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_dcache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0, proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  riscv_dcache #(.BIT_W(32), .LINES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           n_pass = 0;
  int           n_total = 0;
  int           mem_lat = 3;
  int           resp_cnt = 0;
  bit           both_high = 1'b0;
  logic [127:0] mem_model [int];
  logic         op_wr_q [$];
  logic [27:0]  op_addr_q [$];
  logic [127:0] last_wb_data = '0;
  int           stalls;

  function automatic logic [127:0] blk_init(input logic [27:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = 32'hC0DE_0000 | (32'(a) << 4) | 32'(i);
    return b;
  endfunction

  // Memory responder: pulses mem_ready after mem_lat cycles of an active request.
  always @(negedge clk) begin
    if (mem_read && mem_write) both_high = 1'b1;
    if (mem_ready) begin
      mem_ready = 1'b0;
      resp_cnt  = 0;
    end else if (mem_read || mem_write) begin
      resp_cnt++;
      if (resp_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        op_wr_q.push_back(mem_write);
        op_addr_q.push_back(mem_addr);
        if (mem_write) begin
          mem_model[int'(mem_addr)] = mem_wdata;
          last_wb_data = mem_wdata;
        end else begin
          mem_rdata = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)]
                                                       : blk_init(mem_addr);
        end
      end
    end else begin
      resp_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents a request and returns once it completes (stall low), bounded.
  task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] wd, output int st);
    @(negedge clk);
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    st = 0;
    #1;
    while (proc_stall && st < 200) begin
      st++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  task automatic clear_log();
    op_wr_q.delete();
    op_addr_q.delete();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stall_noreq", proc_stall, 0);
    proc_read = 1'b1; proc_addr = 30'h10;
    #1;
    chk("rst_stall_req", proc_stall, 1);
    chk("rst_rdata", proc_rdata, 0);
    proc_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Cold read miss, clean victim
    clear_log(); mem_lat = 3;
    access(1, 0, 30'h10, 0, stalls);
    chk("cold_stall_cycles", stalls, 4);
    chk("cold_rdata", proc_rdata, 32'hC0DE_0040);
    chk("cold_op_count", op_wr_q.size(), 1);
    chk("cold_op_is_read", op_wr_q[0], 0);
    chk("cold_mem_addr", op_addr_q[0], 28'h4);
    idle();

    // Store hit then load hit
    clear_log();
    access(0, 1, 30'h11, 32'hDEAD_BEEF, stalls);
    chk("wr_hit_stall", stalls, 0);
    chk("wr_hit_no_mem", {mem_read, mem_write}, 2'b00);
    idle();
    access(1, 0, 30'h11, 0, stalls);
    chk("rd_hit_stall", stalls, 0);
    chk("rd_hit_rdata", proc_rdata, 32'hDEAD_BEEF);
    idle();
    chk("hit_op_count", op_wr_q.size(), 0);

    // Conflict miss with dirty victim
    clear_log();
    access(1, 0, 30'h91, 0, stalls);
    chk("dirty_stall_cycles", stalls, 8);
    chk("dirty_rdata", proc_rdata, 32'hC0DE_0241);
    chk("dirty_op_count", op_wr_q.size(), 2);
    chk("dirty_op0_write", op_wr_q[0], 1);
    chk("dirty_op0_addr", op_addr_q[0], 28'h4);
    chk("dirty_op1_read", op_wr_q[1], 0);
    chk("dirty_op1_addr", op_addr_q[1], 28'h24);
    chk("dirty_wb_data", last_wb_data,
        {32'hC0DE_0043, 32'hC0DE_0042, 32'hDEAD_BEEF, 32'hC0DE_0040});
    idle();
`ifdef DCACHE_STATS_EN
    @(negedge clk); #1;
    chk("stats_hit_cnt", hit_cnt, 4);
    chk("stats_miss_cnt", miss_cnt, 2);
`endif

    // Clean victim eviction; written-back data returns from memory
    access(1, 0, 30'h11, 0, stalls);
    chk("refetch_stall_cycles", stalls, 4);
    chk("refetch_rdata", proc_rdata, 32'hDEAD_BEEF);
    idle();

    // Reset asserted during ALLOC
    mem_lat = 1000;
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h200;
    @(negedge clk); #1;
    chk("abort_mem_read_on", mem_read, 1);
    chk("abort_mem_addr", mem_addr, 28'h80);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_read_off", mem_read, 0);
    chk("abort_stall", proc_stall, 1);
    @(negedge clk);
    rst_n = 1'b1; proc_read = 1'b0;
    mem_lat = 2;
    access(1, 0, 30'h200, 0, stalls);
    chk("abort_remiss_stall", stalls, 3);
    chk("abort_remiss_rdata", proc_rdata, 32'hC0DE_0800);
    idle();

    // Request dropped mid-ALLOC
    mem_lat = 4;
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h300;
    @(negedge clk);
    @(negedge clk);
    proc_read = 1'b0;
    #1;
    chk("drop_stall_noreq", proc_stall, 0);
    chk("drop_mem_read_held", mem_read, 1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("drop_ready_cycle", {mem_ready, mem_read}, 2'b11);
    @(negedge clk); #1;
    chk("drop_mem_read_off", mem_read, 0);
    access(1, 0, 30'h302, 0, stalls);
    chk("drop_resident_stall", stalls, 0);
    chk("drop_resident_rdata", proc_rdata, 32'hC0DE_0C02);
    idle();

    chk("never_rd_and_wr", both_high, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
